// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    // Instruction addresses are word aligned; the two low bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Request/response link between the fetch stage (master) and the instruction memory (slave).
interface if_fetch_unit_if;
    import if_pkg::*;

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_ready_i;
    logic [XLEN-1:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_data_i
    );

endinterface

// File: rtl/if_perf_cnt.sv
// Pair of saturating event counters for fetch stalls and squashed responses.
module if_perf_cnt
    import if_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_inc_stall,
    input  logic            i_inc_squash,
    output logic [XLEN-1:0] o_cnt_stall,
    output logic [XLEN-1:0] o_cnt_squash
);

    logic [XLEN-1:0] r_cnt_stall;
    logic [XLEN-1:0] r_cnt_squash;

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt_stall  <= '0;
            r_cnt_squash <= '0;
        end else begin
            if (i_inc_stall && (r_cnt_stall != '1)) begin
                r_cnt_stall <= r_cnt_stall + XLEN'(1);
            end
            if (i_inc_squash && (r_cnt_squash != '1)) begin
                r_cnt_squash <= r_cnt_squash + XLEN'(1);
            end
        end
    end

    assign o_cnt_stall  = r_cnt_stall;
    assign o_cnt_squash = r_cnt_squash;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to the instruction memory, holds data across stalls
// and drains squashed requests. Define IF_FETCH_PERF_EN to add the stall/squash counter ports.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic [XLEN-1:0]     branch_target_i,
    if_fetch_unit_if.master     imem,
    output logic [XLEN-1:0]     pc_o,
    output logic [XLEN-1:0]     instr_o,
    output logic                valid_o,
    output logic                fetch_stall_o
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [XLEN-1:0]     cnt_stall_o,
    output logic [XLEN-1:0]     cnt_squash_o
`endif
);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_buf;
    logic [XLEN-1:0] r_tgt;

    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_next;
    logic            w_ready;
    logic            w_req;
    logic [XLEN-1:0] w_addr;

    assign w_target  = word_align(branch_target_i);
    assign w_pc_next = r_pc + PC_STEP;
    assign w_ready   = imem.imem_ready_i;

    // Flush outranks stall; the request address never changes while a request is open.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_REQ;
            r_pc    <= word_align(RESET_PC);
            r_buf   <= '0;
            r_tgt   <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (flush_i) begin
                        if (w_ready) begin
                            r_pc <= w_target;
                        end else begin
                            r_tgt   <= w_target;
                            r_state <= S_DRAIN;
                        end
                    end else if (w_ready) begin
                        if (stall_i) begin
                            r_buf   <= imem.imem_data_i;
                            r_state <= S_HOLD;
                        end else begin
                            r_pc <= w_pc_next;
                        end
                    end
                end
                S_HOLD: begin
                    if (flush_i) begin
                        r_pc    <= w_target;
                        r_state <= S_REQ;
                    end else if (!stall_i) begin
                        r_pc    <= w_pc_next;
                        r_state <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (w_ready) begin
                        r_pc    <= flush_i ? w_target : r_tgt;
                        r_state <= S_REQ;
                    end else if (flush_i) begin
                        r_tgt <= w_target;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    // Memory data passes straight through to instr_o so a zero-wait memory sustains one per cycle.
    always_comb begin
        w_req         = 1'b0;
        w_addr        = '0;
        pc_o          = '0;
        instr_o       = INSTR_NOP;
        valid_o       = 1'b0;
        fetch_stall_o = 1'b0;
        if (!rst_i) begin
            case (r_state)
                S_REQ: begin
                    w_req  = 1'b1;
                    w_addr = r_pc;
                    if (!w_ready) begin
                        fetch_stall_o = 1'b1;
                    end else if (!flush_i) begin
                        valid_o = 1'b1;
                        pc_o    = r_pc;
                        instr_o = imem.imem_data_i;
                    end
                end
                S_HOLD: begin
                    valid_o = 1'b1;
                    pc_o    = r_pc;
                    instr_o = r_buf;
                end
                S_DRAIN: begin
                    w_req         = 1'b1;
                    w_addr        = r_pc;
                    fetch_stall_o = 1'b1;
                end
                default: begin
                    fetch_stall_o = 1'b1;
                end
            endcase
        end
    end

    assign imem.imem_req_o  = w_req;
    assign imem.imem_addr_o = w_addr;

`ifdef IF_FETCH_PERF_EN
    logic            w_squash;
    logic [XLEN-1:0] w_cnt_stall;
    logic [XLEN-1:0] w_cnt_squash;

    // A response is squashed when it lands under a flush or while draining.
    assign w_squash = !rst_i && w_ready &&
                      (((r_state == S_REQ) && flush_i) || (r_state == S_DRAIN));

    if_perf_cnt u_perf_cnt (
        .i_clk        (clk_i),
        .i_rst        (rst_i),
        .i_inc_stall  (fetch_stall_o),
        .i_inc_squash (w_squash),
        .o_cnt_stall  (w_cnt_stall),
        .o_cnt_squash (w_cnt_squash)
    );

    assign cnt_stall_o  = rst_i ? '0 : w_cnt_stall;
    assign cnt_squash_o = rst_i ? '0 : w_cnt_squash;
`endif

endmodule
